fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 imem_req  out  1  instruction fetch request.
REQ-005 imem_addr  out  32  fetch address; equals current PC.
REQ-006 imem_rdata  in  32  instruction word; meaningful only when imem_valid=1.
REQ-007 imem_valid  in  1  memory returns the word for imem_addr this cycle.
REQ-008 stall  in  1  downstream cannot accept a new IF/ID entry.
REQ-009 branch_taken  in  1  redirect request from execute; also flushes IF/ID.
REQ-010 branch_target  in  32  redirect address.
REQ-011 ifid_valid  out  1  IF/ID register holds a live instruction.
REQ-012 ifid_instr  out  32  registered instruction word.
REQ-013 ifid_pc  out  32  PC of ifid_instr.
REQ-014 ifid_pc4  out  32  ifid_pc + 4.
REQ-015 imm_field  out  25  ifid_instr[31:7]; feeds the immediate extension unit.
REQ-016 immsrc  out  3  registered immediate-type predecode of ifid_instr.

Function
REQ-017 FSM states BOOT, FETCH, HOLD are the only states.
REQ-018 BOOT: imem_req=0, one cycle, then FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=PC, combinational from PC register.
REQ-020 FETCH, imem_valid=1, stall=0: IF/ID loads {rdata, PC, PC+4}, ifid_valid=1, PC+=4, stay FETCH.
REQ-021 FETCH, imem_valid=1, stall=1: word captured into a one-entry hold buffer, PC unchanged, go HOLD; IF/ID unchanged.
REQ-022 FETCH, imem_valid=0: PC and IF/ID unchanged, except that ifid_valid is cleared when stall=0, so no instruction is duplicated.
REQ-023 HOLD: imem_req=0; stall=0 loads IF/ID from the hold buffer, PC+=4, go FETCH; stall=1 holds everything.
REQ-024 stall=1 freezes ifid_* and immsrc in every state.
REQ-025 branch_taken=1, any state except BOOT: PC <= {branch_target[31:2],2'b00}, ifid_valid<=0, hold buffer discarded, any same-cycle imem_valid word dropped, next state FETCH; overrides stall.
REQ-026 branch_taken in BOOT is ignored.
REQ-027 Priority: reset > branch_taken > stall > imem_valid.
REQ-028 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-029 immsrc encoding by ifid_instr[6:0]:
- 0000011, 0010011, 1100111 -> 000 (I)
- 0100011 -> 001 (S)
- 1100011 -> 010 (B)
- 0110111, 0010111 -> 011 (U)
- 1101111 -> 100 (J)
- all other opcodes -> 111
REQ-030 immsrc is registered with ifid_instr in the same cycle, never combinational from imem_rdata.
REQ-031 imm_field is a pure slice of ifid_instr; it changes only when ifid_instr changes.

Reset
REQ-032 With rst_n=0 at a rising edge, the following take effect on that edge regardless of other inputs:
- state=BOOT, PC=RESET_PC, ifid_valid=0
- ifid_instr=32'h0000_0013 (NOP), ifid_pc=0, ifid_pc4=0, immsrc=000
- hold buffer empty
REQ-033 Reset asserted mid-HOLD or mid-redirect discards all pending state; the first fetch after release is at RESET_PC.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN defined: adds output fetch_count (out, 32 bits), cleared on reset, incremented by 1 on each IF/ID load (REQ-020 and REQ-023), wrapping at 2^32.
REQ-035 Macro FETCH_PERF_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-036 Release reset, imem_valid=1 every cycle, stall=0 -> imem_addr 0,4,8,...; ifid_valid first high two edges after release; ifid_pc4=ifid_pc+4.
REQ-037 In FETCH with PC=8, stall=1 and imem_valid=1 with rdata=32'h00A00093 -> state HOLD, imem_req=0; after stall drops, ifid_instr=32'h00A00093, ifid_pc=8, immsrc=000, imm_field=25'h0014001, next addr 12.
REQ-038 branch_taken=1 with target 32'h0000_0102 while stall=1 in HOLD -> next imem_addr=32'h0000_0100, ifid_valid=0, buffered word never appears.
REQ-039 Instructions 32'h00112023, 32'hFE000EE3, 32'h123450B7, 32'h0080006F, 32'h00208033 in sequence -> immsrc 001, 010, 011, 100, 111.
REQ-040 Set RESET_PC=32'hFFFF_FFFC and run two fetches -> second imem_addr=32'h0000_0000.
REQ-041 Assert rst_n=0 during HOLD, then release -> ifid_valid=0, first imem_addr=RESET_PC; with FETCH_PERF_CNT_EN defined, fetch_count=0 after reset and equals the number of IF/ID loads.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-entry hold buffer, IF/ID register and immsrc predecode.
// Optional retired-fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [24:0] imm_field,
  output logic [2:0]  immsrc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hbuf;
  logic        ld;
  logic [31:0] ldw;

  function automatic logic [2:0] predec(input logic [6:0] op);
    logic [2:0] r;
    r = 3'b111;
    unique case (1'b1)
      op == 7'b0000011,
      op == 7'b0010011,
      op == 7'b1100111: r = 3'b000;
      op == 7'b0100011: r = 3'b001;
      op == 7'b1100011: r = 3'b010;
      op == 7'b0110111,
      op == 7'b0010111: r = 3'b011;
      op == 7'b1101111: r = 3'b100;
      default:          r = 3'b111;
    endcase
    return r;
  endfunction

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign imm_field = ifid_instr[31:7];

  // An IF/ID load happens only when nothing of higher priority intervenes.
  always_comb begin
    ld  = 1'b0;
    ldw = imem_rdata;
    if (!branch_taken && !stall) begin
      if (state == FETCH && imem_valid) begin
        ld = 1'b1;
      end else if (state == HOLD) begin
        ld  = 1'b1;
        ldw = hbuf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      hbuf       <= 32'h0;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0000_0013;
      ifid_pc    <= 32'h0;
      ifid_pc4   <= 32'h0;
      immsrc     <= 3'b000;
    end else begin
      if (ld) begin
        ifid_valid <= 1'b1;
        ifid_instr <= ldw;
        ifid_pc    <= pc;
        ifid_pc4   <= pc + 32'd4;
        immsrc     <= predec(ldw[6:0]);
        pc         <= pc + 32'd4;
      end
      unique case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (branch_taken) begin
            pc         <= {branch_target[31:2], 2'b00};
            ifid_valid <= 1'b0;
          end else if (stall) begin
            if (imem_valid) begin
              hbuf  <= imem_rdata;
              state <= HOLD;
            end
          end else if (!imem_valid) begin
            ifid_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc         <= {branch_target[31:2], 2'b00};
            ifid_valid <= 1'b0;
            state      <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= 32'h0;
    end else if (ld) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus random traffic checked
// against a transaction-level model of the fetch pipeline.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        imem_valid;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        req1, req2;
  logic [31:0] addr1, addr2, rdata1, rdata2;
  logic        v1, v2;
  logic [31:0] ins1, ins2, pc1, pc2, pc41, pc42;
  logic [24:0] imm1, imm2;
  logic [2:0]  isrc1, isrc2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fc1, fc2;
`endif

  logic [31:0] mem [64];

  int ncmp = 0;
  int nerr = 0;

  // reference model state
  bit          m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_held [$];
  bit          m_v;
  logic [31:0] m_instr, m_ipc, m_ipc4;
  logic [2:0]  m_isrc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  assign rdata1 = mem[addr1[7:2]];
  assign rdata2 = mem[addr2[7:2]];

  fetch_stage u1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req1), .imem_addr(addr1),
    .imem_rdata(rdata1), .imem_valid(imem_valid),
    .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .ifid_valid(v1), .ifid_instr(ins1),
    .ifid_pc(pc1), .ifid_pc4(pc41),
    .imm_field(imm1), .immsrc(isrc1)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc1)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(rdata2), .imem_valid(imem_valid),
    .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .ifid_valid(v2), .ifid_instr(ins2),
    .ifid_pc(pc2), .ifid_pc4(pc42),
    .imm_field(imm2), .immsrc(isrc2)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc2)
`endif
  );

  function automatic logic [2:0] kind(input logic [31:0] w);
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
      7'b0100011:                         return 3'b001;
      7'b1100011:                         return 3'b010;
      7'b0110111, 7'b0010111:             return 3'b011;
      7'b1101111:                         return 3'b100;
      default:                            return 3'b111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic deliver(input logic [31:0] w);
    m_instr = w;
    m_ipc   = m_pc;
    m_ipc4  = m_pc + 32'd4;
    m_isrc  = kind(w);
    m_v     = 1'b1;
    m_pc    = m_pc + 32'd4;
    m_cnt   = m_cnt + 32'd1;
  endtask

  // One clock of fetch behaviour expressed as transactions.
  task automatic model_step();
    logic [31:0] w;
    if (!rst_n) begin
      m_boot  = 1'b1;
      m_pc    = 32'h0;
      m_held.delete();
      m_v     = 1'b0;
      m_instr = 32'h0000_0013;
      m_ipc   = 32'h0;
      m_ipc4  = 32'h0;
      m_isrc  = 3'b000;
      m_cnt   = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target & 32'hFFFF_FFFC;
      m_v  = 1'b0;
      m_held.delete();
    end else if (m_held.size() != 0) begin
      if (!stall) begin
        w = m_held.pop_front();
        deliver(w);
      end
    end else if (stall) begin
      if (imem_valid) m_held.push_back(mem[m_pc[7:2]]);
    end else if (imem_valid) begin
      deliver(mem[m_pc[7:2]]);
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [31:0] slice;
    slice = {7'b0, m_instr[31:7]};
    chk("imem_req", {31'b0, req1},
        {31'b0, (!m_boot && m_held.size() == 0)});
    chk("imem_addr", addr1, m_pc);
    chk("ifid_valid", {31'b0, v1}, {31'b0, m_v});
    chk("ifid_instr", ins1, m_instr);
    chk("ifid_pc", pc1, m_ipc);
    chk("ifid_pc4", pc41, m_ipc4);
    chk("immsrc", {29'b0, isrc1}, {29'b0, m_isrc});
    chk("imm_field", {7'b0, imm1}, slice);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fc1, m_cnt);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit r, input bit s, input bit v,
                       input bit b, input logic [31:0] t);
    rst_n         = r;
    stall         = s;
    imem_valid    = v;
    branch_taken  = b;
    branch_target = t;
  endtask

  logic [6:0]  ops [10];
  logic [31:0] seq [5];
  logic [2:0]  want [5];

  initial begin
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b0110011, 7'b1110011};
    foreach (mem[i]) begin
      logic [31:0] r;
      r = $urandom;
      mem[i] = {r[31:7], ops[$urandom_range(0, 9)]};
    end
    mem[2] = 32'h00A0_0093;
    seq  = '{32'h0011_2023, 32'hFE00_0EE3, 32'h1234_50B7,
             32'h0080_006F, 32'h0020_8033};
    want = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    for (int i = 0; i < 5; i++) mem[32 + i] = seq[i];

    // reset
    drive(0, 0, 1, 0, 32'h0);
    tick();
    tick();
    chk("u2_reset_addr", addr2, 32'hFFFF_FFFC);

    // release, stream with no stall
    drive(1, 0, 1, 0, 32'h0);
    tick();
    chk("boot_no_valid", {31'b0, v1}, 32'd0);
    chk("u2_boot_addr", addr2, 32'hFFFF_FFFC);
    tick();
    chk("first_valid", {31'b0, v1}, 32'd1);
    chk("first_pc", pc1, 32'h0);
    chk("u2_wrap_addr", addr2, 32'h0000_0000);
    tick();
    chk("addr_8", addr1, 32'h8);

    // stall while the word at PC=8 returns
    drive(1, 1, 1, 0, 32'h0);
    tick();
    chk("hold_req", {31'b0, req1}, 32'd0);
    chk("hold_ifid_pc", pc1, 32'h4);
    drive(1, 0, 1, 0, 32'h0);
    tick();
    chk("held_instr", ins1, 32'h00A0_0093);
    chk("held_pc", pc1, 32'h8);
    chk("held_immsrc", {29'b0, isrc1}, 32'd0);
    chk("held_imm", {7'b0, imm1}, 32'h0001_4001);
    chk("after_hold_addr", addr1, 32'hC);

    // redirect while stalled in HOLD
    drive(1, 1, 1, 0, 32'h0);
    tick();
    drive(1, 1, 1, 1, 32'h0000_0102);
    tick();
    chk("redir_addr", addr1, 32'h0000_0100);
    chk("redir_valid", {31'b0, v1}, 32'd0);
    drive(1, 0, 1, 0, 32'h0);
    tick();
    chk("redir_pc", pc1, 32'h0000_0100);

    // immsrc decode sequence
    drive(1, 0, 1, 1, 32'h0000_0080);
    tick();
    drive(1, 0, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("immsrc_seq", {29'b0, isrc1}, {29'b0, want[i]});
    end

    // reset during HOLD
    drive(1, 1, 1, 0, 32'h0);
    tick();
    drive(0, 1, 1, 0, 32'h0);
    tick();
    drive(1, 0, 0, 0, 32'h0);
    tick();
    chk("rst_hold_valid", {31'b0, v1}, 32'd0);
    chk("rst_hold_addr", addr1, 32'h0);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
